// File: rtl/button_input_controller.sv
// Five-button front end: synchronize, debounce, edge-detect, prioritize into a single-entry
// command register, and auto-repeat the movement buttons (left/right/down) while held.
module button_input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 15000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [3:0] controller_in,
  output logic       cmd_valid,
  input  logic       cmd_ack
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW    = $clog2(RepMax + 1);

  localparam logic [3:0] CmdNone   = 4'b0000;
  localparam logic [3:0] CmdLeft   = 4'b0001;
  localparam logic [3:0] CmdRight  = 4'b0010;
  localparam logic [3:0] CmdRotate = 4'b0011;
  localparam logic [3:0] CmdStart  = 4'b0100;
  localparam logic [3:0] CmdDown   = 4'b0101;

  // Bit order: 0 left, 1 right, 2 rotate, 3 down, 4 start.
  logic [4:0]     raw;
  logic [4:0]     sync1_q, sync2_q, db_q, db_prev_q;
  logic [DbW-1:0] db_cnt_q [5];
  logic [4:0]     press;

  assign raw   = {btn_start, btn_down, btn_rotate, btn_right, btn_left};
  assign press = db_q & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Press priority: start > rotate > left > right > down.
  logic       press_valid, press_rep;
  logic [3:0] press_code;
  logic [1:0] press_sel;

  always_comb begin
    press_valid = 1'b1;
    press_rep   = 1'b0;
    press_code  = CmdNone;
    press_sel   = 2'd0;
    if (press[4])      press_code = CmdStart;
    else if (press[2]) press_code = CmdRotate;
    else if (press[0]) begin press_code = CmdLeft;  press_rep = 1'b1; press_sel = 2'd0; end
    else if (press[1]) begin press_code = CmdRight; press_rep = 1'b1; press_sel = 2'd1; end
    else if (press[3]) begin press_code = CmdDown;  press_rep = 1'b1; press_sel = 2'd2; end
    else               press_valid = 1'b0;
  end

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  rep_state_e      state_q, state_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]      rep_btn_q, rep_btn_d;
  logic            rep_level, rep_valid, load_ok, start_repeat;
  logic [3:0]      rep_code;

  always_comb begin
    rep_level = 1'b0;
    rep_code  = CmdNone;
    case (rep_btn_q)
      2'd0:    begin rep_level = db_q[0]; rep_code = CmdLeft;  end
      2'd1:    begin rep_level = db_q[1]; rep_code = CmdRight; end
      2'd2:    begin rep_level = db_q[3]; rep_code = CmdDown;  end
      default: begin rep_level = 1'b0;    rep_code = CmdNone;  end
    endcase
  end

  assign load_ok      = !cmd_valid || cmd_ack;
  assign start_repeat = press_valid && press_rep && load_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rep_cnt_q <= '0;
      rep_btn_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      rep_btn_q <= rep_btn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    rep_btn_d = rep_btn_q;
    if (start_repeat) begin
      state_d   = StDelay;
      rep_cnt_d = '0;
      rep_btn_d = press_sel;
    end else begin
      case (state_q)
        StIdle: rep_cnt_d = '0;
        StDelay: begin
          if (!rep_level) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == RepW'(REPEAT_DELAY - 1)) begin
            state_d   = StRepeat;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (!rep_level) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
          end else if (rep_cnt_q == RepW'(REPEAT_RATE - 1)) begin
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    rep_valid = 1'b0;
    if (rep_level) begin
      if (state_q == StDelay && rep_cnt_q == RepW'(REPEAT_DELAY - 1)) rep_valid = 1'b1;
      if (state_q == StRepeat && rep_cnt_q == RepW'(REPEAT_RATE - 1)) rep_valid = 1'b1;
    end
  end

  // Single-entry command register; a repeat only fills it when no press competes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid     <= 1'b0;
      controller_in <= CmdNone;
    end else if (press_valid && load_ok) begin
      cmd_valid     <= 1'b1;
      controller_in <= press_code;
    end else if (rep_valid && load_ok) begin
      cmd_valid     <= 1'b1;
      controller_in <= rep_code;
    end else if (cmd_valid && cmd_ack) begin
      cmd_valid     <= 1'b0;
      controller_in <= CmdNone;
    end
  end

endmodule

// File: tb/tb_button_input_controller.sv
// Directed bench for button_input_controller with small debounce/repeat parameters.
module tb_button_input_controller;

  logic       clk;
  logic       reset;
  logic       btn_left, btn_right, btn_rotate, btn_down, btn_start;
  logic [3:0] controller_in;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       ack_drv;
  logic       tie_ack;
  int         checks;
  int         errors;
  int         seen;

  assign cmd_ack = tie_ack ? cmd_valid : ack_drv;

  button_input_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_rotate   (btn_rotate),
    .btn_down     (btn_down),
    .btn_start    (btn_start),
    .controller_in(controller_in),
    .cmd_valid    (cmd_valid),
    .cmd_ack      (cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; tie_ack = 1'b0; ack_drv = 1'b0;
    btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; btn_start = 0;
    @(negedge clk);
    step(2);
    chk("reset_valid", 32'(cmd_valid), 0);
    chk("reset_code", 32'(controller_in), 0);
    reset = 1'b0;

    // Rotate: accepted after edge 7, held without ack, never repeats.
    btn_rotate = 1'b1;
    step(6);
    chk("rot_early", 32'(cmd_valid), 0);
    step(1);
    chk("rot_valid", 32'(cmd_valid), 1);
    chk("rot_code", 32'(controller_in), 32'h3);
    step(30);
    chk("rot_hold_valid", 32'(cmd_valid), 1);
    chk("rot_hold_code", 32'(controller_in), 32'h3);
    btn_rotate = 1'b0; ack_drv = 1'b1;
    step(1);
    chk("rot_ack_valid", 32'(cmd_valid), 0);
    chk("rot_ack_code", 32'(controller_in), 0);
    step(1);
    chk("idle_ack_ignored", 32'(cmd_valid), 0);
    ack_drv = 1'b0;
    step(10);

    // Left glitch of 3 cycles is filtered; 4 cycles is accepted.
    btn_left = 1'b1;
    step(3);
    btn_left = 1'b0;
    step(12);
    chk("glitch3_none", 32'(cmd_valid), 0);
    btn_left = 1'b1;
    step(4);
    btn_left = 1'b0;
    step(2);
    chk("glitch4_early", 32'(cmd_valid), 0);
    step(1);
    chk("glitch4_valid", 32'(cmd_valid), 1);
    chk("glitch4_code", 32'(controller_in), 32'h1);

    // Down press while left pending and unacked is dropped.
    btn_down = 1'b1;
    step(10);
    chk("pend_valid", 32'(cmd_valid), 1);
    chk("pend_code", 32'(controller_in), 32'h1);
    ack_drv = 1'b1;
    step(1);
    ack_drv = 1'b0;
    chk("pend_ack_valid", 32'(cmd_valid), 0);
    chk("pend_ack_code", 32'(controller_in), 0);
    step(30);
    chk("down_dropped", 32'(cmd_valid), 0);
    btn_down = 1'b0;
    step(10);

    // Start and down together: start wins, down lost, start never repeats.
    btn_start = 1'b1; btn_down = 1'b1;
    step(7);
    chk("prio_valid", 32'(cmd_valid), 1);
    chk("prio_code", 32'(controller_in), 32'h4);
    ack_drv = 1'b1;
    step(1);
    ack_drv = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (cmd_valid) seen++;
    end
    chk("prio_no_follow", 32'(seen), 0);
    btn_start = 1'b0; btn_down = 1'b0;
    step(10);

    // Right held with ack tied to valid: t0, t0+20, t0+28, t0+36.
    tie_ack = 1'b1; btn_right = 1'b1;
    step(7);
    chk("rep_t0_valid", 32'(cmd_valid), 1);
    chk("rep_t0_code", 32'(controller_in), 32'h2);
    step(1);
    chk("rep_t1_gap", 32'(cmd_valid), 0);
    step(18);
    chk("rep_t19_gap", 32'(cmd_valid), 0);
    step(1);
    chk("rep_t20_valid", 32'(cmd_valid), 1);
    chk("rep_t20_code", 32'(controller_in), 32'h2);
    step(7);
    chk("rep_t27_gap", 32'(cmd_valid), 0);
    step(1);
    chk("rep_t28_valid", 32'(cmd_valid), 1);
    step(8);
    chk("rep_t36_valid", 32'(cmd_valid), 1);
    chk("rep_t36_code", 32'(controller_in), 32'h2);
    btn_right = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (cmd_valid) seen++;
    end
    chk("rep_stop", 32'(seen), 0);

    // Reset while pending and repeating; held button re-debounces afterwards.
    btn_right = 1'b1;
    step(27);
    chk("rst_pre_valid", 32'(cmd_valid), 1);
    chk("rst_pre_state", 32'(dut.state_q), 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_code", 32'(controller_in), 0);
    chk("rst_state", 32'(dut.state_q), 0);
    step(6);
    chk("rst_redeb_early", 32'(cmd_valid), 0);
    step(1);
    chk("rst_redeb_valid", 32'(cmd_valid), 1);
    chk("rst_redeb_code", 32'(controller_in), 32'h2);
    btn_right = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_input_controller.md
BUTTON_INPUT_CONTROLLER -- requirements
Module: button_input_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive cycles a raw level must persist before it is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 15000000, meaning cycles from an accepted press to the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000, meaning cycles between subsequent auto-repeats.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_left, btn_right, btn_rotate, btn_down, btn_start  input  1 each  raw asynchronous pushbutton levels, 1 = pressed.
REQ-007 controller_in  output  4  command code to grid controller; 0000 when cmd_valid=0.
REQ-008 cmd_valid  output  1  controller_in holds a pending command.
REQ-009 cmd_ack  input  1  consumer accepted the pending command this cycle.

Function
REQ-010 Command codes SHALL be: 0000 none, 0001 left, 0010 right, 0011 rotate, 0100 start, 0101 down.
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debounce counter; the debounced level SHALL flip only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle clears the counter.
REQ-013 A press event SHALL be a 0->1 transition of a debounced level; releases SHALL generate no command.
REQ-014 Latency: raw level high and stable from edge 1 SHALL cause cmd_valid=1 after edge DEBOUNCE_CYCLES+3 when no command is pending.
REQ-015 Simultaneous press events SHALL be resolved by priority start > rotate > left > right > down; losing events SHALL be discarded.
REQ-016 A command SHALL be loaded when cmd_valid=0, or when cmd_valid=1 and cmd_ack=1 in the same cycle (back-to-back, no bubble).
REQ-017 A pending command SHALL hold controller_in stable until acknowledged; events arriving while pending and not acked SHALL be discarded (no queue).
REQ-018 cmd_ack while cmd_valid=0 SHALL be ignored.
REQ-019 The repeat FSM SHALL have states IDLE, DELAY and REPEAT, plus a repeat counter and a 2-bit repeat-button register.
REQ-020 IDLE->DELAY SHALL occur when a left, right or down command is loaded; the counter is cleared and the button recorded. Rotate and start SHALL never repeat.
REQ-021 DELAY: when the counter reaches REPEAT_DELAY-1, the FSM SHALL emit a repeat event for the recorded button, clear the counter and enter REPEAT.
REQ-022 REPEAT: every REPEAT_RATE cycles the FSM SHALL emit a repeat event.
REQ-023 DELAY or REPEAT SHALL go to IDLE in the cycle the recorded button's debounced level is 0.
REQ-024 A newly loaded left, right or down press SHALL retarget the FSM to DELAY with the counter cleared; a loaded rotate or start SHALL leave the FSM unchanged.
REQ-025 Repeat events SHALL have lower priority than every press event; they SHALL be discarded if not loadable per REQ-016, and the counter SHALL continue without accumulating.
REQ-026 Counter widths SHALL hold their parameter values without overflow; wrap-around SHALL occur only via explicit clear.

Reset
REQ-027 Reset SHALL clear synchronizers, debounced levels (to 0), all counters, cmd_valid=0, controller_in=0000 and the repeat FSM to IDLE.
REQ-028 Reset SHALL take priority over all other activity, including mid-debounce and a pending command; buttons held through reset SHALL produce a press event only after re-debouncing.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-029 btn_rotate high from edge 1, cmd_ack=0 -> cmd_valid=1 and controller_in=0011 after edge 7, held indefinitely; no repeats.
REQ-030 btn_left glitch high for 3 cycles, then low -> no command; glitch high for 4 cycles -> one 0001 command.
REQ-031 btn_start and btn_down rise in the same cycle -> single command 0100; no down command follows.
REQ-032 btn_right held, cmd_ack tied to cmd_valid -> 0010 at t0, repeats at t0+20, t0+28, t0+36; release -> repeats stop within DEBOUNCE_CYCLES+3 cycles.
REQ-033 Pending 0001 unacked while btn_down presses -> down discarded; ack -> cmd_valid=0 next cycle, controller_in=0000.
REQ-034 reset asserted with cmd_valid=1 and the FSM in REPEAT -> next cycle cmd_valid=0, FSM IDLE; a still-held button re-issues its command DEBOUNCE_CYCLES+3 cycles after reset release.
